avmm_to_avst_cmd_bridge: RTL
============================

// Module: avmm_to_avst_cmd_bridge
// PURPOSE
//  Parametrised Avalon-MM slave to AVST command/response bridge, the next generation of the CCI-P AVMM requestor front end.
//  Converts AVMM reads, writes and write bursts into a registered AVST command stream carrying byteenable and start-of-burst.
//  Returns read data on a registered AVMM readdata path.
//  Bounds outstanding read beats with a credit counter and reports protocol errors through sticky flags.
// PARAMETERS
//  DATA_WIDTH      512  data width in bits; byteenable width is DATA_WIDTH/8
//  ADDR_WIDTH      48   AVMM address width
//  BURST_WIDTH     3    burstcount width; legal burst length 1..2**BURST_WIDTH-1
//  MAX_RD_PENDING  64   maximum outstanding read beats (>= 2**BURST_WIDTH-1)
//  CMD_WIDTH       (derived localparam) = 2+BURST_WIDTH+ADDR_WIDTH+DATA_WIDTH/8+DATA_WIDTH
// PORTS
//  clk                 in   1             clock
//  reset_n             in   1             asynchronous active-low reset
//  avmm_address        in   ADDR_WIDTH    request address
//  avmm_writedata      in   DATA_WIDTH    write data
//  avmm_byteenable     in   DATA_WIDTH/8  byte enables
//  avmm_burstcount     in   BURST_WIDTH   burst length (beats)
//  avmm_read           in   1             read request
//  avmm_write          in   1             write request / write beat
//  avmm_waitrequest    out  1             stall
//  avmm_readdata       out  DATA_WIDTH    read response data
//  avmm_readdatavalid  out  1             read response valid
//  avst_avcmd_data     out  CMD_WIDTH     command {read,sop,burst,addr,be,wdata}, MSB first
//  avst_avcmd_valid    out  1             command valid
//  avst_avcmd_ready    in   1             command ready
//  avst_rd_rsp_data    in   DATA_WIDTH    response data
//  avst_rd_rsp_valid   in   1             response valid
//  avst_rd_rsp_ready   out  1             response ready
//  rd_pending          out  $clog2(MAX_RD_PENDING+1)  outstanding read beats
//  err_flags           out  4             sticky: [0] rd&wr together, [1] read mid write burst, [2] burstcount==0, [3] unexpected rsp
// BEHAVIOUR
//  Reset:
//   - All outputs are 0, except avmm_waitrequest=1.
//   - The skid buffer, write-burst state, credit counter and err_flags are cleared.
//  Command path:
//   - 2-entry skid buffer; avst_avcmd_valid/data are driven from flops only.
//   - Transfer occurs when avst_avcmd_valid & avst_avcmd_ready.
//  Accept:
//   - A request is accepted when (avmm_read|avmm_write) & ~avmm_waitrequest.
//   - An accepted command is visible on avst_avcmd_data the next cycle when the buffer was empty (latency 1).
//  Waitrequest:
//   - avmm_waitrequest = buffer_full | (avmm_read & rd_pending+burstcount > MAX_RD_PENDING).
//   - It is combinational on the AVMM inputs and registered state; it is 1 whenever reset_n is low.
//  Write FSM, states W_IDLE and W_BURST:
//   - W_IDLE: an accepted write emits sop=1 with the live addr and burst.
//   - If burst>1, latch addr/burst, set beats_left=burst-1 and go to W_BURST.
//   - W_BURST: each accepted beat emits sop=0 with the latched addr/burst and decrements beats_left.
//   - Return to W_IDLE when beats_left reaches 0 on an accepted beat.
//  Reads:
//   - An accepted read is always 1 command with sop=1, read=1; wdata is don't-care.
//   - rd_pending += burstcount on accept.
//  Responses:
//   - avst_rd_rsp_ready=1 whenever out of reset.
//   - Each valid beat is registered to avmm_readdata/avmm_readdatavalid one cycle later.
//   - rd_pending -= 1 per response beat.
//   - A read accept and a response beat in the same cycle update rd_pending by burstcount-1.
//  Errors (commands are still forwarded):
//   - rd&wr asserted together: treat as a read; set err[0].
//   - avmm_read in W_BURST: stall with waitrequest until the burst ends; set err[1].
//   - burstcount 0: forward the command, leave the credit count unchanged; set err[2].
//   - Response with rd_pending==0: forward it, hold the counter at 0 (no underflow); set err[3].
//  Reset mid-burst: the FSM, buffer and counter clear asynchronously; in-flight commands and responses are discarded.
// TESTING
//  - Single read, addr=0x100, burst=1, ready=1: cmd appears 1 cycle later with read=1, sop=1; rd_pending=1; one response beat gives readdatavalid 1 cycle later and rd_pending=0.
//  - Write burst of 4 at addr=0x40: 4 cmds are emitted; sop only on beat 0; all 4 carry addr 0x40 and burst 4; the FSM returns to W_IDLE after beat 4.
//  - MAX_RD_PENDING=8, three reads of burst 3 with no responses: the 3rd is held in waitrequest until 1 response beat arrives (6+3>8 becomes 5+3<=8).
//  - avst_avcmd_ready=0 for 5 cycles during a write stream: at most 2 writes are accepted before waitrequest; no command is lost or reordered after ready returns.
//  - Read accept and response beat in the same cycle with rd_pending=2, burst=2: rd_pending=3 next cycle.
//  - Unexpected response at rd_pending=0 sets err[3]; read+write together sets err[0]; then assert reset_n=0 mid write burst: all outputs are at reset values, err_flags=0.

Source files
------------

// File: rtl/avmm_to_avst_cmd_bridge.sv
// Avalon-MM slave to AVST command/response bridge.
// Registered command skid buffer, write-burst tracking, read credits and sticky errors.
module avmm_to_avst_cmd_bridge #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 48,
  parameter int BURST_WIDTH    = 3,
  parameter int MAX_RD_PENDING = 64,
  localparam int BE_WIDTH   = DATA_WIDTH/8,
  localparam int CMD_WIDTH  = 2+BURST_WIDTH+ADDR_WIDTH+BE_WIDTH+DATA_WIDTH,
  localparam int PEND_WIDTH = $clog2(MAX_RD_PENDING+1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  avmm_address,
  input  logic [DATA_WIDTH-1:0]  avmm_writedata,
  input  logic [BE_WIDTH-1:0]    avmm_byteenable,
  input  logic [BURST_WIDTH-1:0] avmm_burstcount,
  input  logic                   avmm_read,
  input  logic                   avmm_write,
  output logic                   avmm_waitrequest,
  output logic [DATA_WIDTH-1:0]  avmm_readdata,
  output logic                   avmm_readdatavalid,
  output logic [CMD_WIDTH-1:0]   avst_avcmd_data,
  output logic                   avst_avcmd_valid,
  input  logic                   avst_avcmd_ready,
  input  logic [DATA_WIDTH-1:0]  avst_rd_rsp_data,
  input  logic                   avst_rd_rsp_valid,
  output logic                   avst_rd_rsp_ready,
  output logic [PEND_WIDTH-1:0]  rd_pending,
  output logic [3:0]             err_flags
);

  typedef enum logic {W_IDLE, W_BURST} wstate_t;

  wstate_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH-1:0] beats_q, beats_d;

  logic [CMD_WIDTH-1:0]   buf0_q, buf1_q, cmd_new;
  logic [1:0]             cnt_q, cnt_d;
  logic                   valid_q;
  logic [PEND_WIDTH-1:0]  pend_q, pend_inc;
  logic [PEND_WIDTH:0]    rd_sum;
  logic [3:0]             err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   rvalid_q;

  logic is_rd, is_wr, buf_full, credit_block, rd_in_burst;
  logic accept, rd_acc, wr_acc, pop, rsp_dec, rsp_unexp;
  logic cmd_sop;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [BURST_WIDTH-1:0] cmd_burst;

  // A simultaneous read and write is handled as a read.
  assign is_rd        = avmm_read;
  assign is_wr        = avmm_write & ~avmm_read;
  assign buf_full     = (cnt_q == 2'd2);
  assign rd_sum       = {1'b0, pend_q} + (PEND_WIDTH+1)'(avmm_burstcount);
  assign credit_block = is_rd & (rd_sum > (PEND_WIDTH+1)'(MAX_RD_PENDING));
  assign rd_in_burst  = is_rd & (state_q == W_BURST);

  assign avmm_waitrequest = ~reset_n | buf_full | credit_block | rd_in_burst;

  assign accept = (avmm_read | avmm_write) & ~avmm_waitrequest;
  assign rd_acc = accept & is_rd;
  assign wr_acc = accept & is_wr;
  assign pop    = valid_q & avst_avcmd_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    beats_d   = beats_q;
    cmd_sop   = 1'b1;
    cmd_addr  = avmm_address;
    cmd_burst = avmm_burstcount;
    unique case (state_q)
      W_IDLE: begin
        if (wr_acc && avmm_burstcount > BURST_WIDTH'(1)) begin
          state_d = W_BURST;
          addr_d  = avmm_address;
          burst_d = avmm_burstcount;
          beats_d = avmm_burstcount - BURST_WIDTH'(1);
        end
      end
      W_BURST: begin
        cmd_sop   = 1'b0;
        cmd_addr  = addr_q;
        cmd_burst = burst_q;
        if (wr_acc) begin
          beats_d = beats_q - BURST_WIDTH'(1);
          if (beats_q == BURST_WIDTH'(1)) state_d = W_IDLE;
        end
      end
    endcase
  end

  assign cmd_new = {is_rd, cmd_sop, cmd_burst, cmd_addr,
                    avmm_byteenable, avmm_writedata};

  always_comb begin
    cnt_d = cnt_q;
    if (accept & ~pop) cnt_d = cnt_q + 2'd1;
    else if (~accept & pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= W_IDLE;
      addr_q  <= '0;
      burst_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      beats_q <= beats_d;
    end
  end

  // Head entry drives the stream; a pop with push only happens at depth 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
      case ({accept, pop})
        2'b10: begin
          if (cnt_q == 2'd0) buf0_q <= cmd_new;
          else buf1_q <= cmd_new;
        end
        2'b01: buf0_q <= buf1_q;
        2'b11: buf0_q <= cmd_new;
        default: ;
      endcase
    end
  end

  assign rsp_dec   = avst_rd_rsp_valid & (pend_q != '0);
  assign rsp_unexp = avst_rd_rsp_valid & (pend_q == '0);
  assign pend_inc  = rd_acc ? PEND_WIDTH'(avmm_burstcount) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      pend_q   <= pend_q + pend_inc - PEND_WIDTH'(rsp_dec);
      err_q    <= err_q | {rsp_unexp,
                           accept & (avmm_burstcount == '0),
                           rd_in_burst,
                           avmm_read & avmm_write};
      rvalid_q <= avst_rd_rsp_valid;
      if (avst_rd_rsp_valid) rdata_q <= avst_rd_rsp_data;
    end
  end

  assign avst_avcmd_data    = buf0_q;
  assign avst_avcmd_valid   = valid_q;
  assign avst_rd_rsp_ready  = reset_n;
  assign avmm_readdata      = rdata_q;
  assign avmm_readdatavalid = rvalid_q;
  assign rd_pending         = pend_q;
  assign err_flags          = err_q;

endmodule
